// File: rtl/jtag_pkg.sv
// ---------------------------------------------------------------------------
// jtag_pkg
// Shared definitions for the JTAG TAP controller slice.
//  - tap_state_t : the 16 IEEE 1149.1 TAP states with their conventional
//                  4-bit encodings (the same codes many vendors expose on
//                  debug buses, so waveform viewers decode them directly).
//  - IR_CAPTURE  : the two mandatory LSBs loaded into the IR shift register
//                  in Capture-IR; upper bits are zero-filled by the user.
// ---------------------------------------------------------------------------
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    // Mandatory 1149.1 capture value: LSB pair is 2'b01 so a board-level
    // tester can spot broken scan chains from the first two tdo bits.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_fsm.sv
// ---------------------------------------------------------------------------
// jtag_tap_fsm
// The 16-state TAP controller. Next state depends only on tms; every state
// decode the datapath needs is registered so downstream logic never sees
// decode glitches from the state register transitions.
// Ports:
//  clk       in   TCK, rising-edge
//  reset_    in   asynchronous active-low reset (TRST_)
//  tms       in   test mode select
//  enter_tlr out  combinational: the next clk edge lands in Test-Logic-Reset
//  cap_ir    out  registered: currently in Capture-IR
//  sh_ir     out  registered: currently in Shift-IR
//  upd_ir    out  registered: currently in Update-IR
//  cap_dr    out  registered: currently in Capture-DR
//  sh_dr     out  registered: currently in Shift-DR
//  upd_dr    out  registered: currently in Update-DR
// ---------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic clk,
    input  logic reset_,
    input  logic tms,
    output logic enter_tlr,
    output logic cap_ir,
    output logic sh_ir,
    output logic upd_ir,
    output logic cap_dr,
    output logic sh_dr,
    output logic upd_dr
);

    tap_state_t state;
    tap_state_t next_state;

    // Standard TAP transition graph. Each state has one tms value that
    // leaves and one that holds (or two distinct exits), so a run of five
    // tms=1 always funnels into TLR from anywhere.
    always_comb begin
        next_state = state;
        case (state)
            TLR:    next_state = tms ? TLR    : RTI;
            RTI:    next_state = tms ? SEL_DR : RTI;
            SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
            SEL_IR: next_state = tms ? TLR    : CAP_IR;
            CAP_DR: next_state = tms ? EX1_DR : SH_DR;
            SH_DR:  next_state = tms ? EX1_DR : SH_DR;
            EX1_DR: next_state = tms ? UPD_DR : PAU_DR;
            PAU_DR: next_state = tms ? EX2_DR : PAU_DR;
            EX2_DR: next_state = tms ? UPD_DR : SH_DR;
            UPD_DR: next_state = tms ? SEL_DR : RTI;
            CAP_IR: next_state = tms ? EX1_IR : SH_IR;
            SH_IR:  next_state = tms ? EX1_IR : SH_IR;
            EX1_IR: next_state = tms ? UPD_IR : PAU_IR;
            PAU_IR: next_state = tms ? EX2_IR : PAU_IR;
            EX2_IR: next_state = tms ? UPD_IR : SH_IR;
            UPD_IR: next_state = tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    // The IR must be reset on the same edge that enters TLR, so this one
    // is taken from the next-state logic rather than registered.
    assign enter_tlr = (next_state == TLR);

    // State register plus registered decodes. The decodes are computed
    // from next_state so each flag is high exactly while the state
    // register holds the matching state.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state  <= TLR;
            cap_ir <= 1'b0;
            sh_ir  <= 1'b0;
            upd_ir <= 1'b0;
            cap_dr <= 1'b0;
            sh_dr  <= 1'b0;
            upd_dr <= 1'b0;
        end else begin
            state  <= next_state;
            cap_ir <= (next_state == CAP_IR);
            sh_ir  <= (next_state == SH_IR);
            upd_ir <= (next_state == UPD_IR);
            cap_dr <= (next_state == CAP_DR);
            sh_dr  <= (next_state == SH_DR);
            upd_dr <= (next_state == UPD_DR);
        end
    end

endmodule

// File: rtl/jtag_tap_dr_ctrl.sv
// ---------------------------------------------------------------------------
// jtag_tap_dr_ctrl
// TAP controller, instruction register and data-register select for a bank
// of shared-scan-path JTAG data registers. Instruction code k < NUM_DR
// selects external DR k; every other code selects the internal 1-bit
// BYPASS register.
// Parameters:
//  IR_WIDTH  instruction register width (>= 2)
//  NUM_DR    number of external data registers
//  IR_RESET  instruction loaded on entry to Test-Logic-Reset
// Ports:
//  clk         in   TCK, all flops rising-edge
//  reset_      in   asynchronous active-low reset (TRST_)
//  tms         in   test mode select
//  tdi         in   test data in
//  tdo         out  test data out, combinational from the active shift path
//  tdo_en      out  high while in Shift-DR or Shift-IR
//  dr_sel      out  one-hot select of the external DRs, all zero = bypass
//  dr_shift    out  shift enable to the external DRs
//  dr_update   out  one-cycle pulse in Update-DR
//  dr_scanin   out  serial data to every external DR (tdi)
//  dr_scanout  in   serial data from each external DR
//  ir_q        out  currently active instruction
// ---------------------------------------------------------------------------
module jtag_tap_dr_ctrl
    import jtag_pkg::*;
#(
    parameter int unsigned          IR_WIDTH = 4,
    parameter int unsigned          NUM_DR   = 4,
    parameter logic [IR_WIDTH-1:0]  IR_RESET = {IR_WIDTH{1'b1}}
)(
    input  logic                clk,
    input  logic                reset_,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic [NUM_DR-1:0]   dr_sel,
    output logic                dr_shift,
    output logic                dr_update,
    output logic                dr_scanin,
    input  logic [NUM_DR-1:0]   dr_scanout,
    output logic [IR_WIDTH-1:0] ir_q
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE_WORD = IR_WIDTH'(IR_CAPTURE);

    logic                enter_tlr;
    logic                cap_ir;
    logic                sh_ir;
    logic                upd_ir;
    logic                cap_dr;
    logic                sh_dr;
    logic                upd_dr;
    logic [IR_WIDTH-1:0] ir_shift;
    logic                bypass;
    logic                bypass_sel;
    logic                dr_tdo;

    jtag_tap_fsm u_fsm (
        .clk       (clk),
        .reset_    (reset_),
        .tms       (tms),
        .enter_tlr (enter_tlr),
        .cap_ir    (cap_ir),
        .sh_ir     (sh_ir),
        .upd_ir    (upd_ir),
        .cap_dr    (cap_dr),
        .sh_dr     (sh_dr),
        .upd_dr    (upd_dr)
    );

    // Instruction register. The shift stage is a scratch path; only the
    // edge leaving Update-IR commits it to ir_q, so an aborted IR scan
    // (TLR or reset) never applies a half-shifted instruction.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ir_shift <= '0;
            ir_q     <= IR_RESET;
        end else begin
            if (cap_ir) begin
                ir_shift <= IR_CAPTURE_WORD;
            end else if (sh_ir) begin
                ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
            end

            if (enter_tlr) begin
                ir_q <= IR_RESET;
            end else if (upd_ir) begin
                ir_q <= ir_shift;
            end
        end
    end

    // Any code outside the external-DR range falls back to BYPASS.
    assign bypass_sel = (32'(ir_q) >= NUM_DR);

    // Select decode from the registered instruction only, so dr_sel can
    // change just once per Update-IR and never glitches mid-scan.
    for (genvar k = 0; k < NUM_DR; k++) begin : g_sel
        assign dr_sel[k] = (32'(ir_q) == 32'(k));
    end

    // BYPASS cell: captures 0 so the first tdo bit of a bypass scan is a
    // known zero, then acts as a one-cycle delay of tdi.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            bypass <= 1'b0;
        end else if (cap_dr) begin
            bypass <= 1'b0;
        end else if (sh_dr && bypass_sel) begin
            bypass <= tdi;
        end
    end

    // dr_sel is one-hot (or zero), so an AND-OR picks the selected
    // scanout without needing an index narrower than ir_q.
    assign dr_tdo = |(dr_sel & dr_scanout);

    always_comb begin
        tdo = 1'b0;
        if (sh_ir) begin
            tdo = ir_shift[0];
        end else if (sh_dr) begin
            tdo = bypass_sel ? bypass : dr_tdo;
        end
    end

    assign tdo_en    = sh_ir | sh_dr;
    assign dr_shift  = sh_dr;
    assign dr_update = upd_dr;
    assign dr_scanin = tdi;

endmodule
